gestor_acesso: RTL and testbench
================================

GESTOR_ACESSO -- requirements
Module: gestor_acesso

Interface
REQ-001 Parameter: VAGAS_MAX, default 9; parking capacity, range 1..15.
REQ-002 Parameter: SENHA, default 4'b1010; valid access code.
REQ-003 Parameter: TEMPO_LIBERADO, default 1000; cycles the gate stays open awaiting a vehicle.
REQ-004 Parameter: TEMPO_ERRO, default 500; cycles the ERRO word is held.
REQ-005 Parameter: BLOQUEIO_CICLOS, default 2000; lockout length in cycles.
REQ-006 Port: clk, input, 1; single clock, all state on its rising edge.
REQ-007 Port: rst_n, input, 1; asynchronous active-low reset.
REQ-008 Port: senha, input, 4; code switches, sampled only on a confirm event.
REQ-009 Port: btn_confirma, input, 1; asynchronous confirm button, active high.
REQ-010 Port: sensor_entrada, input, 1; asynchronous entry-gate vehicle sensor, active high.
REQ-011 Port: sensor_saida, input, 1; asynchronous exit vehicle sensor, active high.
REQ-012 Port: palavra_index, output, 4; one-hot display request: bit0 CHEIO, bit1 LIBERADO, bit2 PARE, bit3 ERRO.
REQ-013 Port: cancela, output, 1; gate open.
REQ-014 Port: vagas_ocupadas, output, 4; occupied-space count.

Function
REQ-015 Each asynchronous input SHALL pass a 2-FF synchronizer plus a rising-edge detector; an input rising before clock edge k SHALL be acted on at edge k+2 (state visible after edge k+2); held levels SHALL produce one event only.
REQ-016 palavra_index SHALL be registered and exactly one-hot at all times.
REQ-017 OCIOSO: palavra=PARE, cancela=0.
- vagas_ocupadas==VAGAS_MAX -> CHEIO (priority over confirm).
- Confirm with senha==SENHA -> LIBERADO; tentativas cleared.
- Confirm with a wrong senha -> tentativas+1 (saturating at 3) -> ERRO.
REQ-018 LIBERADO: palavra=LIBERADO, cancela=1, timer loaded with TEMPO_LIBERADO.
- Entry event -> vagas+1; -> CHEIO if the new count equals VAGAS_MAX, else OCIOSO.
- Timer expiry without an entry -> OCIOSO, count unchanged.
- Entry and expiry on the same cycle: entry wins.
REQ-019 ERRO: palavra=ERRO, cancela=0; -> OCIOSO after TEMPO_ERRO cycles.
REQ-020 CHEIO: palavra=CHEIO, cancela=0; -> OCIOSO when vagas_ocupadas<VAGAS_MAX.
REQ-021 Confirm events SHALL be ignored, and not counted as attempts, in LIBERADO, ERRO, CHEIO and BLOQUEIO.
REQ-022 Exit events SHALL decrement vagas_ocupadas in every state; an exit at count 0 SHALL be ignored.
REQ-023 Entry events outside LIBERADO SHALL be ignored; vagas_ocupadas never exceeds VAGAS_MAX.
REQ-024 Simultaneous entry and exit events in LIBERADO SHALL leave the count unchanged; state -> OCIOSO.

Reset
REQ-025 rst_n low SHALL immediately force:
- state=OCIOSO, palavra_index=4'b0100, cancela=0, vagas_ocupadas=0;
- tentativas=0, timers=0, synchronizer and edge registers=0.
REQ-026 Reset asserted mid-operation, including in LIBERADO with the gate open, SHALL abort the operation with no count change.
REQ-027 Release SHALL be followed by normal operation from OCIOSO on the next clock edge.

Configuration
REQ-028 Macro BLOQUEIO_TENTATIVAS_EN defined: a third consecutive wrong confirm -> BLOQUEIO instead of ERRO.
- BLOQUEIO: palavra=ERRO, cancela=0; lasts BLOCKEIO_CICLOS cycles, then -> OCIOSO with tentativas cleared.
REQ-029 Macro BLOQUEIO_TENTATIVAS_EN undefined: the BLOQUEIO state and tentativas counter are absent; every wrong confirm -> ERRO.

Verification
REQ-030 Reset, then senha=1010 with a confirm pulse -> palavra=0010 and cancela=1 after edge +2; entry pulse -> vagas=1, palavra=0100, cancela=0.
REQ-031 senha=0011 with a confirm -> palavra=1000 for exactly 500 cycles, then 0100; vagas unchanged.
REQ-032 9 valid entries -> after the 9th, palavra=0001 and confirm ignored; one exit -> vagas=8, palavra=0100.
REQ-033 LIBERADO with no entry for 1000 cycles -> cancela=0, palavra=0100, vagas unchanged; entry and exit on the same cycle with vagas=3 -> vagas=3.
REQ-034 Exit pulse with vagas=0 -> vagas stays 0; rst_n low while in LIBERADO -> immediately palavra=0100, cancela=0, vagas=0.
REQ-035 With BLOQUEIO_TENTATIVAS_EN: 3 wrong confirms -> palavra=1000 for 2000 cycles, and a correct senha is ignored during that time. Without the macro: the same stimulus -> three separate 500-cycle ERRO windows.

Source files
------------

// File: rtl/gestor_acesso.sv
// gestor_acesso -- parking access controller.
//
// Purpose: validates an access code, opens the entry gate for one vehicle,
// keeps the occupied-space count and drives a one-hot display request.
//
// Ports:
//   clk             system clock, all state on its rising edge
//   rst_n           asynchronous active-low reset
//   senha[3:0]      code switches, sampled when a confirm event is acted on
//   btn_confirma    asynchronous confirm button (active high)
//   sensor_entrada  asynchronous entry-gate vehicle sensor (active high)
//   sensor_saida    asynchronous exit vehicle sensor (active high)
//   palavra_index   one-hot display: bit0 CHEIO, bit1 LIBERADO, bit2 PARE, bit3 ERRO
//   cancela         gate open
//   vagas_ocupadas  occupied-space count
//
// Optional feature: define BLOQUEIO_TENTATIVAS_EN to add a lockout state
// entered on the third consecutive wrong code. Without it every wrong code
// gives a plain ERRO window and no attempt counter exists.
//
// States:
//   state    | meaning
//   OCIOSO   | idle, waiting for a code (PARE)
//   LIBERADO | gate open, waiting for a vehicle or timeout
//   ERRO     | wrong code shown for TEMPO_ERRO cycles
//   CHEIO    | parking full, leaves when a space frees
//   BLOQUEIO | lockout after repeated wrong codes (optional)

module gestor_acesso #(
   parameter int          VAGAS_MAX       = 9,
   parameter logic [3:0]  SENHA           = 4'b1010,
   parameter int          TEMPO_LIBERADO  = 1000,
   parameter int          TEMPO_ERRO      = 500,
   parameter int          BLOQUEIO_CICLOS = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] senha,
   input  logic       btn_confirma,
   input  logic       sensor_entrada,
   input  logic       sensor_saida,
   output logic [3:0] palavra_index,
   output logic       cancela,
   output logic [3:0] vagas_ocupadas
);

   localparam int T_A   = (TEMPO_LIBERADO > TEMPO_ERRO) ? TEMPO_LIBERADO : TEMPO_ERRO;
   localparam int T_MAX = (T_A > BLOQUEIO_CICLOS) ? T_A : BLOQUEIO_CICLOS;
   localparam int TW    = $clog2(T_MAX + 1);

   localparam logic [3:0] VMAX = 4'(VAGAS_MAX);

   localparam logic [3:0] PAL_CHEIO    = 4'b0001;
   localparam logic [3:0] PAL_LIBERADO = 4'b0010;
   localparam logic [3:0] PAL_PARE     = 4'b0100;
   localparam logic [3:0] PAL_ERRO     = 4'b1000;

   // Timers count down from length-1 so a state lasts exactly its length.
   localparam logic [TW-1:0] CARGA_LIB  = TW'(TEMPO_LIBERADO - 1);
   localparam logic [TW-1:0] CARGA_ERRO = TW'(TEMPO_ERRO - 1);
`ifdef BLOQUEIO_TENTATIVAS_EN
   localparam logic [TW-1:0] CARGA_BLOQ = TW'(BLOQUEIO_CICLOS - 1);

   typedef enum logic [2:0] {
      OCIOSO, LIBERADO, ERRO, CHEIO, BLOQUEIO
   } estado_t;
`else
   typedef enum logic [1:0] {
      OCIOSO, LIBERADO, ERRO, CHEIO
   } estado_t;
`endif

   estado_t         estado;
   logic [TW-1:0]   timer;
   logic [3:0]      vagas_nxt;
`ifdef BLOQUEIO_TENTATIVAS_EN
   logic [1:0]      tentativas;
`endif

   // Synchronizers: bit0 confirm, bit1 entry, bit2 exit.
   logic [2:0] sinc_a, sinc_b, sinc_d;
   logic [2:0] evento;
   logic       ev_conf, ev_ent, ev_sai;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sinc_a <= '0;
         sinc_b <= '0;
         sinc_d <= '0;
      end else begin
         sinc_a <= {sensor_saida, sensor_entrada, btn_confirma};
         sinc_b <= sinc_a;
         sinc_d <= sinc_b;
      end
   end

   assign evento  = sinc_b & ~sinc_d;
   assign ev_conf = evento[0];
   assign ev_ent  = evento[1];
   assign ev_sai  = evento[2];

   // An entry together with an exit in LIBERADO cancels out; exits at 0 are dropped.
   always_comb begin
      vagas_nxt = vagas_ocupadas;
      if (estado == LIBERADO && ev_ent) begin
         if (!ev_sai)
            vagas_nxt = vagas_ocupadas + 4'd1;
      end else if (ev_sai && vagas_ocupadas != 4'd0) begin
         vagas_nxt = vagas_ocupadas - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado         <= OCIOSO;
         palavra_index  <= PAL_PARE;
         cancela        <= 1'b0;
         vagas_ocupadas <= 4'd0;
         timer          <= '0;
`ifdef BLOQUEIO_TENTATIVAS_EN
         tentativas     <= 2'd0;
`endif
      end else begin
         vagas_ocupadas <= vagas_nxt;
         case (estado)
            OCIOSO: begin
               if (vagas_ocupadas == VMAX) begin
                  estado        <= CHEIO;
                  palavra_index <= PAL_CHEIO;
               end else if (ev_conf) begin
                  if (senha == SENHA) begin
                     estado        <= LIBERADO;
                     palavra_index <= PAL_LIBERADO;
                     cancela       <= 1'b1;
                     timer         <= CARGA_LIB;
`ifdef BLOQUEIO_TENTATIVAS_EN
                     tentativas    <= 2'd0;
`endif
                  end else begin
`ifdef BLOQUEIO_TENTATIVAS_EN
                     if (tentativas != 2'd3)
                        tentativas <= tentativas + 2'd1;
                     if (tentativas >= 2'd2) begin
                        estado        <= BLOQUEIO;
                        palavra_index <= PAL_ERRO;
                        timer         <= CARGA_BLOQ;
                     end else begin
                        estado        <= ERRO;
                        palavra_index <= PAL_ERRO;
                        timer         <= CARGA_ERRO;
                     end
`else
                     estado        <= ERRO;
                     palavra_index <= PAL_ERRO;
                     timer         <= CARGA_ERRO;
`endif
                  end
               end
            end
            LIBERADO: begin
               // Entry is checked before the timeout so a car at the last cycle counts.
               if (ev_ent) begin
                  cancela <= 1'b0;
                  if (vagas_nxt == VMAX) begin
                     estado        <= CHEIO;
                     palavra_index <= PAL_CHEIO;
                  end else begin
                     estado        <= OCIOSO;
                     palavra_index <= PAL_PARE;
                  end
               end else if (timer == '0) begin
                  estado        <= OCIOSO;
                  palavra_index <= PAL_PARE;
                  cancela       <= 1'b0;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            ERRO: begin
               if (timer == '0) begin
                  estado        <= OCIOSO;
                  palavra_index <= PAL_PARE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            CHEIO: begin
               if (vagas_nxt < VMAX) begin
                  estado        <= OCIOSO;
                  palavra_index <= PAL_PARE;
               end
            end
`ifdef BLOQUEIO_TENTATIVAS_EN
            BLOQUEIO: begin
               if (timer == '0) begin
                  estado        <= OCIOSO;
                  palavra_index <= PAL_PARE;
                  tentativas    <= 2'd0;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
`endif
            default: begin
               estado        <= OCIOSO;
               palavra_index <= PAL_PARE;
               cancela       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gestor_acesso.sv
// tb_gestor_acesso -- bench for gestor_acesso: directed scenarios plus
// random pulses, each cycle compared against a behavioural model.

module tb_gestor_acesso;

   localparam int         VMAX = 9;
   localparam logic [3:0] SEN  = 4'b1010;
   localparam int         TL   = 1000;
   localparam int         TE   = 500;
   localparam int         BC   = 2000;
`ifdef BLOQUEIO_TENTATIVAS_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   localparam int M_IDLE = 0, M_OPEN = 1, M_ERR = 2, M_FULL = 3, M_LOCK = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] senha = 4'd0;
   logic       btn_confirma = 1'b0;
   logic       sensor_entrada = 1'b0;
   logic       sensor_saida = 1'b0;
   logic [3:0] palavra_index;
   logic       cancela;
   logic [3:0] vagas_ocupadas;

   gestor_acesso #(
      .VAGAS_MAX(VMAX), .SENHA(SEN), .TEMPO_LIBERADO(TL),
      .TEMPO_ERRO(TE), .BLOQUEIO_CICLOS(BC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .senha(senha),
      .btn_confirma(btn_confirma), .sensor_entrada(sensor_entrada),
      .sensor_saida(sensor_saida), .palavra_index(palavra_index),
      .cancela(cancela), .vagas_ocupadas(vagas_ocupadas)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: mode, cycles left in timed modes, count, wrong-code streak.
   int m_mode, m_rem, m_vagas, m_tent;
   bit hc[4], he[4], hx[4];

   function automatic logic [3:0] m_pal();
      case (m_mode)
         M_OPEN:          return 4'b0010;
         M_ERR, M_LOCK:   return 4'b1000;
         M_FULL:          return 4'b0001;
         default:         return 4'b0100;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_rem = 0; m_vagas = 0; m_tent = 0;
      for (int i = 0; i < 4; i++) begin hc[i] = 0; he[i] = 0; hx[i] = 0; end
   endtask

   // An input rising just before edge n-2 is acted on at edge n.
   task automatic model_edge();
      bit ce, ee, xe;
      int nv;
      for (int i = 3; i > 0; i--) begin hc[i] = hc[i-1]; he[i] = he[i-1]; hx[i] = hx[i-1]; end
      hc[0] = btn_confirma; he[0] = sensor_entrada; hx[0] = sensor_saida;
      ce = hc[2] && !hc[3];
      ee = he[2] && !he[3];
      xe = hx[2] && !hx[3];
      nv = m_vagas;
      if (xe && m_vagas > 0) nv = m_vagas - 1;
      case (m_mode)
         M_IDLE: begin
            if (m_vagas == VMAX) m_mode = M_FULL;
            else if (ce) begin
               if (senha == SEN) begin
                  m_mode = M_OPEN; m_rem = TL; m_tent = 0;
               end else begin
                  if (m_tent < 3) m_tent++;
                  if (LOCK && m_tent == 3) begin m_mode = M_LOCK; m_rem = BC; end
                  else begin m_mode = M_ERR; m_rem = TE; end
               end
            end
         end
         M_OPEN: begin
            if (ee) begin
               nv = xe ? m_vagas : m_vagas + 1;
               m_mode = (nv == VMAX) ? M_FULL : M_IDLE;
            end else begin
               m_rem--;
               if (m_rem == 0) m_mode = M_IDLE;
            end
         end
         M_ERR: begin
            m_rem--;
            if (m_rem == 0) m_mode = M_IDLE;
         end
         M_FULL: if (nv < VMAX) m_mode = M_IDLE;
         M_LOCK: begin
            m_rem--;
            if (m_rem == 0) begin m_mode = M_IDLE; m_tent = 0; end
         end
         default: m_mode = M_IDLE;
      endcase
      m_vagas = nv;
   endtask

   // One clock: inputs already driven (at negedge); model follows the edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("pal", 32'(palavra_index), 32'(m_pal()));
      check("can", 32'(cancela), 32'(m_mode == M_OPEN));
      check("vag", 32'(vagas_ocupadas), 32'(m_vagas));
      check("onehot", 32'($countones(palavra_index)), 32'd1);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic pulse(input bit c, input bit e, input bit x, input int hi, input int lo);
      btn_confirma = c; sensor_entrada = e; sensor_saida = x;
      run(hi);
      btn_confirma = 1'b0; sensor_entrada = 1'b0; sensor_saida = 1'b0;
      run(lo);
   endtask

   task automatic enter_car();
      senha = SEN;
      pulse(1, 0, 0, 1, 3);
      pulse(0, 1, 0, 1, 3);
   endtask

   // Called at a negedge; reset effect must be visible before any edge.
   task automatic do_reset();
      btn_confirma = 1'b0; sensor_entrada = 1'b0; sensor_saida = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_pal", 32'(palavra_index), 32'h4);
      check("rst_can", 32'(cancela), 32'd0);
      check("rst_vag", 32'(vagas_ocupadas), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int cnt;
   int exp_len;
   int c_hi, c_tot, e_hi, e_tot, x_hi, x_tot;

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // Valid code, open latency, one entry.
      senha = SEN;
      btn_confirma = 1'b1; step();
      check("lat_e0", 32'(palavra_index), 32'h4);
      btn_confirma = 1'b0; step();
      check("lat_e1", 32'(palavra_index), 32'h4);
      step();
      check("open_pal", 32'(palavra_index), 32'h2);
      check("open_can", 32'(cancela), 32'd1);
      sensor_entrada = 1'b1; run(1);
      sensor_entrada = 1'b0; run(2);
      check("entry_vag", 32'(vagas_ocupadas), 32'd1);
      check("entry_pal", 32'(palavra_index), 32'h4);
      check("entry_can", 32'(cancela), 32'd0);

      // Wrong code: ERRO window length.
      senha = 4'b0011;
      btn_confirma = 1'b1; step();
      btn_confirma = 1'b0;
      cnt = 0;
      for (int i = 0; i < 800; i++) begin
         step();
         if (palavra_index == 4'b1000) cnt++;
      end
      check("erro_len", 32'(cnt), 32'd500);
      check("erro_vag", 32'(vagas_ocupadas), 32'd1);
      check("erro_end", 32'(palavra_index), 32'h4);

      // Fill the parking, confirm ignored, one exit frees it.
      do_reset();
      repeat (VMAX) enter_car();
      check("full_pal", 32'(palavra_index), 32'h1);
      check("full_vag", 32'(vagas_ocupadas), 32'(VMAX));
      senha = SEN;
      pulse(1, 0, 0, 1, 4);
      check("full_conf_pal", 32'(palavra_index), 32'h1);
      check("full_conf_can", 32'(cancela), 32'd0);
      pulse(0, 0, 1, 1, 3);
      check("full_exit_vag", 32'(vagas_ocupadas), 32'(VMAX - 1));
      check("full_exit_pal", 32'(palavra_index), 32'h4);

      // Gate timeout without an entry.
      do_reset();
      senha = SEN;
      btn_confirma = 1'b1; step();
      btn_confirma = 1'b0;
      cnt = 0;
      for (int i = 0; i < 1200; i++) begin
         step();
         if (cancela) cnt++;
      end
      check("open_len", 32'(cnt), 32'd1000);
      check("tout_pal", 32'(palavra_index), 32'h4);
      check("tout_vag", 32'(vagas_ocupadas), 32'd0);

      // Entry and exit together in LIBERADO at count 3.
      repeat (3) enter_car();
      pulse(1, 0, 0, 1, 3);
      pulse(0, 1, 1, 1, 3);
      check("simul_vag", 32'(vagas_ocupadas), 32'd3);
      check("simul_pal", 32'(palavra_index), 32'h4);

      // Exit at zero, reset while gate open, restart.
      do_reset();
      pulse(0, 0, 1, 1, 3);
      check("exit0_vag", 32'(vagas_ocupadas), 32'd0);
      enter_car();
      pulse(1, 0, 0, 1, 3);
      check("pre_rst_can", 32'(cancela), 32'd1);
      do_reset();
      pulse(1, 0, 0, 1, 3);
      check("post_rst_can", 32'(cancela), 32'd1);

      // Three consecutive wrong codes; a valid code during the last window.
      do_reset();
      for (int w = 0; w < 3; w++) begin
         senha = 4'b0110;
         btn_confirma = 1'b1; step();
         btn_confirma = 1'b0;
         cnt = 0;
         for (int i = 0; i < 2600; i++) begin
            if (w == 2 && i == 100) begin senha = SEN; btn_confirma = 1'b1; end
            else if (w == 2 && i == 101) btn_confirma = 1'b0;
            step();
            if (palavra_index == 4'b1000) cnt++;
            else if (cnt > 0) break;
         end
         exp_len = (w == 2 && LOCK) ? BC : TE;
         check($sformatf("win%0d_len", w), 32'(cnt), 32'(exp_len));
      end
      check("win_after", 32'(palavra_index), 32'h4);

      // Random pulses on all three inputs.
      do_reset();
      c_hi = 0; c_tot = 0; e_hi = 0; e_tot = 0; x_hi = 0; x_tot = 0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (cyc == 9000) begin
            do_reset();
            c_hi = 0; c_tot = 0; e_hi = 0; e_tot = 0; x_hi = 0; x_tot = 0;
         end
         if (c_tot == 0 && $urandom_range(0, 29) == 0) begin
            c_hi = int'($urandom_range(1, 3));
            c_tot = c_hi + int'($urandom_range(3, 6));
            senha = ($urandom_range(0, 9) < 7) ? SEN : 4'($urandom_range(0, 15));
         end
         if (e_tot == 0 && $urandom_range(0, 5) == 0) begin
            e_hi = int'($urandom_range(1, 3));
            e_tot = e_hi + int'($urandom_range(1, 4));
         end
         if (x_tot == 0 && $urandom_range(0, 24) == 0) begin
            x_hi = int'($urandom_range(1, 3));
            x_tot = x_hi + int'($urandom_range(1, 4));
         end
         btn_confirma   = (c_hi > 0);
         sensor_entrada = (e_hi > 0);
         sensor_saida   = (x_hi > 0);
         step();
         if (c_hi > 0) c_hi--;
         if (c_tot > 0) c_tot--;
         if (e_hi > 0) e_hi--;
         if (e_tot > 0) e_tot--;
         if (x_hi > 0) x_hi--;
         if (x_tot > 0) x_tot--;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
